// File: rtl/trecere_pkg.sv
// Shared phase codes, default minimum dwell times and the phase-order rule
// for the pedestrian-crossing light bus monitor.
package trecere_pkg;

  localparam logic [2:0] UNKNOWN  = 3'd0;
  localparam logic [2:0] CAR_GO   = 3'd1;
  localparam logic [2:0] CAR_WARN = 3'd2;
  localparam logic [2:0] ALL_RED  = 3'd3;
  localparam logic [2:0] PED_GO   = 3'd4;
  localparam logic [2:0] ILLEGAL  = 3'd7;

  localparam int MIN_VERDE_DEF  = 8;
  localparam int MIN_GALBEN_DEF = 3;
  localparam int MIN_ROSU_DEF   = 1;
  localparam int MIN_PVERDE_DEF = 8;

  // ALL_RED is shared by both halves of the cycle; from_ped tells which way it exits.
  function automatic logic legal_move(input logic [2:0] from_ph,
                                      input logic [2:0] to_ph,
                                      input logic       from_ped);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      CAR_GO:   ok = (to_ph == CAR_WARN);
      CAR_WARN: ok = (to_ph == ALL_RED) || (to_ph == PED_GO);
      PED_GO:   ok = (to_ph == ALL_RED) || (to_ph == CAR_GO);
      ALL_RED:  ok = from_ped ? (to_ph == CAR_GO) : (to_ph == PED_GO);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/trecere_decode.sv
// Combinational lamp-pattern decoder: five lamp bits to a phase code plus
// a flag for pedestrian green shown together with car green or yellow.
module trecere_decode
  import trecere_pkg::*;
(
  input  logic [4:0] lamps,
  output logic [2:0] phase,
  output logic       conflict
);

  // Bit order: {p_rosu, p_verde, m_rosu, m_galben, m_verde}
  always_comb begin
    conflict = lamps[3] & (lamps[1] | lamps[0]);
    case (lamps)
      5'b10001: phase = CAR_GO;
      5'b10010: phase = CAR_WARN;
      5'b10100: phase = ALL_RED;
      5'b01100: phase = PED_GO;
      default:  phase = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/trecere_monitor.sv
// Passive checker for the crossing light bus: decodes the lamp phase and
// raises sticky flags for bad lamp patterns, bad phase order and short dwell.
module trecere_monitor
  import trecere_pkg::*;
#(
  parameter int MIN_VERDE  = MIN_VERDE_DEF,
  parameter int MIN_GALBEN = MIN_GALBEN_DEF,
  parameter int MIN_ROSU   = MIN_ROSU_DEF,
  parameter int MIN_PVERDE = MIN_PVERDE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_rosu,
  input  logic       p_verde,
  input  logic       m_rosu,
  input  logic       m_galben,
  input  logic       m_verde,
  input  logic       clr_err,
  output logic [2:0] phase,
  output logic [7:0] dwell,
  output logic [7:0] cycles,
  output logic       err_conflict,
  output logic       err_illegal,
  output logic       err_order,
  output logic       err_short,
  output logic       err_any
);

  localparam logic [7:0] MIN_V8 = 8'(MIN_VERDE);
  localparam logic [7:0] MIN_G8 = 8'(MIN_GALBEN);
  localparam logic [7:0] MIN_R8 = 8'(MIN_ROSU);
  localparam logic [7:0] MIN_P8 = 8'(MIN_PVERDE);

  logic [4:0] lamps_q;
  logic       lamps_vld_q;
  logic [2:0] dec_phase;
  logic       dec_conflict;

  logic [2:0] phase_d, phase_q;
  logic [7:0] dwell_d, dwell_q;
  logic [7:0] cycles_d, cycles_q;
  logic       from_ped_d, from_ped_q;
  logic       err_conflict_d, err_conflict_q;
  logic       err_illegal_d, err_illegal_q;
  logic       err_order_d, err_order_q;
  logic       err_short_d, err_short_q;
  logic       err_any_q;

  logic       changed, sync;
  logic       new_conflict, new_illegal, new_order, new_short;
  logic [7:0] min_dwell;

  trecere_decode u_decode (
    .lamps    (lamps_q),
    .phase    (dec_phase),
    .conflict (dec_conflict)
  );

  always_comb begin
    case (phase_q)
      CAR_GO:   min_dwell = MIN_V8;
      CAR_WARN: min_dwell = MIN_G8;
      ALL_RED:  min_dwell = MIN_R8;
      PED_GO:   min_dwell = MIN_P8;
      default:  min_dwell = 8'd0;
    endcase
  end

  // Stage 2 waits for the first real lamp sample so reset's all-zero capture is not judged.
  always_comb begin
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    cycles_d     = cycles_q;
    from_ped_d   = from_ped_q;
    new_conflict = 1'b0;
    new_illegal  = 1'b0;
    new_order    = 1'b0;
    new_short    = 1'b0;
    changed      = (dec_phase != phase_q);
    sync         = (phase_q == UNKNOWN) || (phase_q == ILLEGAL);

    if (lamps_vld_q) begin
      phase_d = dec_phase;
      if (changed)
        dwell_d = 8'd1;
      else if (dwell_q != 8'hFF)
        dwell_d = dwell_q + 8'd1;

      if (dec_phase == ILLEGAL) begin
        new_illegal  = 1'b1;
        new_conflict = dec_conflict;
      end else if (changed && !sync) begin
        if (legal_move(phase_q, dec_phase, from_ped_q)) begin
          new_short = (dwell_q < min_dwell);
          if (dec_phase == CAR_GO)
            cycles_d = cycles_q + 8'd1;
        end else begin
          new_order = 1'b1;
        end
      end

      if (changed && phase_q == PED_GO)
        from_ped_d = 1'b1;
      else if (changed && phase_q == CAR_WARN)
        from_ped_d = 1'b0;
    end

    err_conflict_d = (err_conflict_q & ~clr_err) | new_conflict;
    err_illegal_d  = (err_illegal_q  & ~clr_err) | new_illegal;
    err_order_d    = (err_order_q    & ~clr_err) | new_order;
    err_short_d    = (err_short_q    & ~clr_err) | new_short;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamps_q        <= 5'd0;
      lamps_vld_q    <= 1'b0;
      phase_q        <= UNKNOWN;
      dwell_q        <= 8'd0;
      cycles_q       <= 8'd0;
      from_ped_q     <= 1'b0;
      err_conflict_q <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_order_q    <= 1'b0;
      err_short_q    <= 1'b0;
      err_any_q      <= 1'b0;
    end else begin
      lamps_q        <= {p_rosu, p_verde, m_rosu, m_galben, m_verde};
      lamps_vld_q    <= 1'b1;
      phase_q        <= phase_d;
      dwell_q        <= dwell_d;
      cycles_q       <= cycles_d;
      from_ped_q     <= from_ped_d;
      err_conflict_q <= err_conflict_d;
      err_illegal_q  <= err_illegal_d;
      err_order_q    <= err_order_d;
      err_short_q    <= err_short_d;
      err_any_q      <= err_conflict_d | err_illegal_d | err_order_d | err_short_d;
    end
  end

  assign phase        = phase_q;
  assign dwell        = dwell_q;
  assign cycles       = cycles_q;
  assign err_conflict = err_conflict_q;
  assign err_illegal  = err_illegal_q;
  assign err_order    = err_order_q;
  assign err_short    = err_short_q;
  assign err_any      = err_any_q;

endmodule

// File: tb/tb_trecere_monitor.sv
// Scoreboard bench for trecere_monitor: a rule-level model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_trecere_monitor;

  localparam logic [4:0] L_CARGO = 5'b10001;
  localparam logic [4:0] L_WARN  = 5'b10010;
  localparam logic [4:0] L_ALLR  = 5'b10100;
  localparam logic [4:0] L_PEDGO = 5'b01100;
  localparam logic [4:0] L_CONFL = 5'b01001;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_rosu, p_verde, m_rosu, m_galben, m_verde, clr_err;
  logic [2:0] phase;
  logic [7:0] dwell, cycles;
  logic       err_conflict, err_illegal, err_order, err_short, err_any;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb[$];

  // Reference model state, stepped once per clock edge
  int   m_phase, m_dwell, m_cycles;
  bit   m_fp, m_valid;
  bit   [3:0] m_err;
  logic [4:0] m_prev;
  bit   allowed [0:1][0:7][0:7];
  int   min_of [0:7] = '{0, 8, 3, 1, 8, 0, 0, 0};
  logic [4:0] lamp_of [0:4];

  trecere_monitor dut (
    .clk(clk), .rst(rst),
    .p_rosu(p_rosu), .p_verde(p_verde), .m_rosu(m_rosu),
    .m_galben(m_galben), .m_verde(m_verde), .clr_err(clr_err),
    .phase(phase), .dwell(dwell), .cycles(cycles),
    .err_conflict(err_conflict), .err_illegal(err_illegal),
    .err_order(err_order), .err_short(err_short), .err_any(err_any)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dut_pack();
    return {phase, dwell, cycles, err_conflict, err_illegal, err_order, err_short, err_any};
  endfunction

  // One car lamp and one pedestrian lamp; pedestrian green only beside car red.
  function automatic int ph_of(input logic [4:0] l);
    if ($countones(l[4:3]) != 1 || $countones(l[2:0]) != 1) return 7;
    if (l[3]) return l[2] ? 4 : 7;
    if (l[0]) return 1;
    if (l[1]) return 2;
    return 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_cycles = 0;
    m_fp = 0; m_valid = 0; m_err = 4'b0; m_prev = 5'b0;
  endtask

  task automatic model_step(input logic [4:0] lamps, input logic clr);
    int np;
    bit nc, ni, no, ns;
    nc = 0; ni = 0; no = 0; ns = 0;
    if (m_valid) begin
      np = ph_of(m_prev);
      if (np == 7) begin
        ni = 1;
        nc = m_prev[3] & (m_prev[1] | m_prev[0]);
      end else if (np != m_phase && m_phase != 0 && m_phase != 7) begin
        if (allowed[m_fp][m_phase][np]) begin
          ns = (m_dwell < min_of[m_phase]);
          if (np == 1) m_cycles = (m_cycles + 1) % 256;
        end else begin
          no = 1;
        end
      end
      if (np != m_phase) begin
        if (m_phase == 4) m_fp = 1;
        if (m_phase == 2) m_fp = 0;
        m_dwell = 1;
      end else if (m_dwell < 255) begin
        m_dwell = m_dwell + 1;
      end
      m_phase = np;
    end
    m_err = (clr ? 4'b0 : m_err) | {nc, ni, no, ns};
    m_prev = lamps;
    m_valid = 1;
    sb.push_back({3'(m_phase), 8'(m_dwell), 8'(m_cycles), m_err, |m_err});
  endtask

  task automatic applyStimulus(input logic [4:0] lamps, input logic clr, input int n);
    repeat (n) begin
      {p_rosu, p_verde, m_rosu, m_galben, m_verde} = lamps;
      clr_err = clr;
      @(posedge clk);
      model_step(lamps, clr);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("scoreboard", 32'(dut_pack()), 32'(e));
    end
  end

  initial begin
    logic [4:0] pat;
    int hold, sel, saved_cycles;
    int cand[$];

    for (int f = 0; f < 2; f++) begin
      allowed[f][1][2] = 1;
      allowed[f][2][3] = 1; allowed[f][2][4] = 1;
      allowed[f][4][3] = 1; allowed[f][4][1] = 1;
    end
    allowed[0][3][4] = 1;
    allowed[1][3][1] = 1;
    lamp_of = '{5'b0, L_CARGO, L_WARN, L_ALLR, L_PEDGO};

    rst = 1'b1; clr_err = 1'b0;
    {p_rosu, p_verde, m_rosu, m_galben, m_verde} = L_CARGO;
    model_reset();
    #12;
    checkOutput("reset_state", 32'(dut_pack()), 32'd0);
    rst = 1'b0;

    // Legal loop with the second CAR_GO entry counting one cycle
    applyStimulus(L_CARGO, 0, 10);
    applyStimulus(L_WARN, 0, 3);
    applyStimulus(L_ALLR, 0, 2);
    applyStimulus(L_PEDGO, 0, 8);
    applyStimulus(L_ALLR, 0, 1);
    applyStimulus(L_CARGO, 0, 2);
    @(negedge clk);
    checkOutput("loop_state", 32'({phase, cycles, err_any}), 32'({3'd1, 8'd1, 1'b0}));

    applyStimulus(L_CARGO, 0, 8);
    applyStimulus(L_WARN, 0, 2);
    applyStimulus(L_PEDGO, 0, 2);
    @(negedge clk);
    checkOutput("short_warn", 32'({phase, err_short, err_any, err_order}), 32'({3'd4, 1'b1, 1'b1, 1'b0}));

    applyStimulus(L_PEDGO, 1, 8);
    applyStimulus(L_CARGO, 0, 8);
    applyStimulus(L_PEDGO, 0, 2);
    @(negedge clk);
    checkOutput("order_car_ped", 32'({phase, err_order}), 32'({3'd4, 1'b1}));

    applyStimulus(L_PEDGO, 1, 1);
    saved_cycles = m_cycles;
    applyStimulus(L_CONFL, 0, 1);
    applyStimulus(L_CARGO, 0, 1);
    @(negedge clk);
    checkOutput("illegal_phase", 32'({phase, err_illegal, err_conflict}), 32'({3'd7, 1'b1, 1'b1}));
    applyStimulus(L_CARGO, 0, 1);
    @(negedge clk);
    checkOutput("resync", 32'({phase, err_order, cycles}), 32'({3'd1, 1'b0, 8'(saved_cycles)}));

    applyStimulus(5'b0, 0, 1);
    applyStimulus(5'b0, 1, 1);
    @(negedge clk);
    checkOutput("clr_vs_illegal", 32'(err_illegal), 32'd1);
    applyStimulus(L_CARGO, 0, 2);
    applyStimulus(L_CARGO, 1, 1);
    @(negedge clk);
    checkOutput("clr_all", 32'({err_conflict, err_illegal, err_order, err_short, err_any}), 32'd0);

    // Asynchronous reset between edges, lamps moving to CAR_GO meanwhile
    applyStimulus(L_CARGO, 0, 6);
    applyStimulus(L_WARN, 0, 3);
    applyStimulus(L_PEDGO, 0, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 32'(dut_pack()), 32'd0);
    model_reset();
    {p_rosu, p_verde, m_rosu, m_galben, m_verde} = L_CARGO;
    @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(L_CARGO, 0, 3);
    @(negedge clk);
    checkOutput("post_reset", 32'({phase, cycles, err_any}), 32'({3'd1, 8'd0, 1'b0}));

    applyStimulus(L_CARGO, 0, 262);
    @(negedge clk);
    checkOutput("dwell_saturate", 32'(dwell), 32'd255);

    for (int k = 0; k < 258; k++) begin
      applyStimulus(L_WARN, 0, 1);
      applyStimulus(L_PEDGO, 0, 1);
      applyStimulus(L_CARGO, 0, 1);
    end

    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 19);
      cand.delete();
      for (int t = 1; t <= 4; t++)
        if (m_phase >= 1 && m_phase <= 4 && allowed[m_fp][m_phase][t]) cand.push_back(t);
      if (sel < 2)
        pat = 5'($urandom);
      else if (sel < 15 && cand.size() != 0)
        pat = lamp_of[cand[$urandom_range(0, cand.size() - 1)]];
      else
        pat = lamp_of[$urandom_range(1, 4)];
      hold = $urandom_range(1, 10);
      applyStimulus(pat, ($urandom_range(0, 15) == 0), hold);
    end

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
